// File: rtl/pipeline_pkg.sv
// Shared pipeline constants and watchdog state encoding.
package pipeline_pkg;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
   localparam logic [31:0] RESET_PC  = 32'h0040_0000;

   typedef enum logic [1:0] {
      IDLE,
      COUNTING,
      TIMEOUT
   } wd_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: async active-low reset, sync clear, enable.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         en,
   input  logic         clr,
   output logic [W-1:0] count
);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (en && (count != '1)) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/if_id_pipe_register.sv
// IF/ID pipeline register with stall, flush and stall watchdog.
// Define IFID_PERF_CNT_EN to build the stall/flush/bubble perf counters.
module if_id_pipe_register #(
   parameter int             N         = 32,
   parameter logic [N-1:0]   RESET_PC  = N'(pipeline_pkg::RESET_PC),
   parameter int             MAX_STALL = 15,
   parameter int             CNT_W     = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [N-1:0]     IF_PC,
   input  logic [N-1:0]     IF_PCPlus4,
   input  logic [N-1:0]     IF_Instruction,
   input  logic             IF_Valid,
   input  logic             Stall,
   input  logic             Flush,
   output logic [N-1:0]     ID_PC,
   output logic [N-1:0]     ID_PCPlus4,
   output logic [N-1:0]     ID_Instruction,
   output logic             ID_Valid,
   output logic             StallTimeout,
   output logic [CNT_W-1:0] StallCount,
   output logic [CNT_W-1:0] FlushCount,
   output logic [CNT_W-1:0] BubbleCount
);

   import pipeline_pkg::*;

   localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(MAX_STALL - 1);

   logic stall_act;
   logic load;

   assign stall_act = Stall && !Flush;
   assign load      = !Stall && !Flush;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ID_PC          <= RESET_PC;
         ID_PCPlus4     <= RESET_PC + N'(4);
         ID_Instruction <= N'(NOP_INSTR);
         ID_Valid       <= 1'b0;
      end else if (Flush) begin
         ID_Instruction <= N'(NOP_INSTR);
         ID_Valid       <= 1'b0;
      end else if (!Stall) begin
         ID_PC          <= IF_PC;
         ID_PCPlus4     <= IF_PCPlus4;
         ID_Instruction <= IF_Valid ? IF_Instruction
                                    : N'(NOP_INSTR);
         ID_Valid       <= IF_Valid;
      end
   end

   wd_state_t        wd_state;
   wd_state_t        wd_next;
   logic             wd_en;
   logic             wd_clr;
   logic [CNT_W-1:0] wd_count;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wd_state <= IDLE;
      end else begin
         wd_state <= wd_next;
      end
   end

   // The transition to TIMEOUT lands on the same edge the count hits MAX_STALL.
   always_comb begin
      wd_next = wd_state;
      wd_en   = 1'b0;
      wd_clr  = 1'b0;
      unique case (wd_state)
         IDLE: begin
            if (stall_act) begin
               wd_en   = 1'b1;
               wd_next = (MAX_STALL <= 1) ? TIMEOUT : COUNTING;
            end
         end
         COUNTING: begin
            if (!stall_act) begin
               wd_clr  = 1'b1;
               wd_next = IDLE;
            end else begin
               wd_en = 1'b1;
               if (wd_count == WD_LAST) begin
                  wd_next = TIMEOUT;
               end
            end
         end
         TIMEOUT: begin
            wd_next = TIMEOUT;
         end
         default: begin
            wd_next = IDLE;
         end
      endcase
   end

   sat_counter #(.W(CNT_W)) u_wd_cnt (
      .clk   (clk),
      .reset (reset),
      .en    (wd_en),
      .clr   (wd_clr),
      .count (wd_count)
   );

   assign StallTimeout = (wd_state == TIMEOUT);

`ifdef IFID_PERF_CNT_EN
   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .reset (reset),
      .en    (stall_act),
      .clr   (1'b0),
      .count (StallCount)
   );

   sat_counter #(.W(CNT_W)) u_flush_cnt (
      .clk   (clk),
      .reset (reset),
      .en    (Flush),
      .clr   (1'b0),
      .count (FlushCount)
   );

   sat_counter #(.W(CNT_W)) u_bubble_cnt (
      .clk   (clk),
      .reset (reset),
      .en    (load && !IF_Valid),
      .clr   (1'b0),
      .count (BubbleCount)
   );
`else
   logic unused_perf;
   assign unused_perf = load;
   assign StallCount  = '0;
   assign FlushCount  = '0;
   assign BubbleCount = '0;
`endif

endmodule
